// File: rtl/dmg_timer.sv
// DMG DIV/TIMA/TMA/TAC timer: free-running 16-bit divider, falling-edge TIMA tick,
// delayed TMA reload on overflow with a one-clock interrupt pulse.
module dmg_timer #(
    parameter int unsigned OVF_DELAY = 4
) (
    input  logic       clk,
    input  logic       res,
    input  logic [1:0] addr,
    input  logic [7:0] din,
    input  logic       wr,
    output logic [7:0] dout,
    output logic       int_timer
);

    typedef enum logic [1:0] {
        StRun,
        StOvf,
        StReload
    } state_e;

    localparam logic [2:0] OvfLoad = 3'(OVF_DELAY - 1);

    logic [15:0] div_q;
    logic [7:0]  tima_q;
    logic [7:0]  tma_q;
    logic [2:0]  tac_q;
    logic        t_prev_q;
    logic [2:0]  ovf_cnt_q;
    logic        int_q;
    state_e      state_q;

    logic       wr_div, wr_tima, wr_tma, wr_tac;
    logic       tap_bit, t, fall;
    logic [7:0] tma_next;
    logic [7:0] inc_base;

    assign wr_div  = wr && (addr == 2'd0);
    assign wr_tima = wr && (addr == 2'd1);
    assign wr_tma  = wr && (addr == 2'd2);
    assign wr_tac  = wr && (addr == 2'd3);

    always_comb begin
        tap_bit = 1'b0;
        unique case (tac_q[1:0])
            2'd0: tap_bit = div_q[9];
            2'd1: tap_bit = div_q[3];
            2'd2: tap_bit = div_q[5];
            2'd3: tap_bit = div_q[7];
            default: tap_bit = 1'b0;
        endcase
    end

    assign t    = tac_q[2] & tap_bit;
    assign fall = t_prev_q & ~t;

    // A TMA write lands in TIMA both on the reload edge and during the reload clock.
    assign tma_next = wr_tma ? din : tma_q;
    assign inc_base = (state_q == StReload) ? tma_next : tima_q;

    always_ff @(posedge clk) begin
        if (res) begin
            div_q     <= 16'h0000;
            tima_q    <= 8'h00;
            tma_q     <= 8'h00;
            tac_q     <= 3'b000;
            t_prev_q  <= 1'b0;
            ovf_cnt_q <= 3'd0;
            int_q     <= 1'b0;
            state_q   <= StRun;
        end else begin
            div_q    <= wr_div ? 16'h0000 : div_q + 16'd1;
            tma_q    <= tma_next;
            t_prev_q <= t;
            int_q    <= 1'b0;
            if (wr_tac) begin
                tac_q <= din[2:0];
            end

            case (state_q)
                StRun: begin
                    if (wr_tima) begin
                        tima_q <= din;
                    end else if (fall) begin
                        if (inc_base == 8'hFF) begin
                            tima_q    <= 8'h00;
                            ovf_cnt_q <= OvfLoad;
                            state_q   <= StOvf;
                        end else begin
                            tima_q <= inc_base + 8'd1;
                        end
                    end
                end
                StOvf: begin
                    if (wr_tima) begin
                        tima_q    <= din;
                        ovf_cnt_q <= 3'd0;
                        state_q   <= StRun;
                    end else if (ovf_cnt_q == 3'd0) begin
                        tima_q  <= tma_next;
                        int_q   <= 1'b1;
                        state_q <= StReload;
                    end else begin
                        ovf_cnt_q <= ovf_cnt_q - 3'd1;
                    end
                end
                StReload: begin
                    // TIMA writes are dropped here; a tick bumps the reloaded value.
                    state_q <= StRun;
                    tima_q  <= inc_base;
                    if (fall) begin
                        if (inc_base == 8'hFF) begin
                            tima_q    <= 8'h00;
                            ovf_cnt_q <= OvfLoad;
                            state_q   <= StOvf;
                        end else begin
                            tima_q <= inc_base + 8'd1;
                        end
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

    always_comb begin
        dout = 8'h00;
        unique case (addr)
            2'd0: dout = div_q[15:8];
            2'd1: dout = tima_q;
            2'd2: dout = tma_q;
            2'd3: dout = {5'b11111, tac_q};
            default: dout = 8'h00;
        endcase
    end

    assign int_timer = int_q;

endmodule
